// File: rtl/wb_write_sequencer_if.sv
// ---------------------------------------------------------------------------
// wb_write_sequencer_if
//   Handshake bundle between the MEM/WB pipeline register and the writeback
//   sequencer. One transfer carries one retired instruction with up to two
//   register writes.
//
//   master : MEM/WB side (drives the instruction, observes in_ready)
//   slave  : sequencer side (consumes the instruction, drives in_ready)
//
//   Signals
//     in_valid           MEM/WB presents an instruction
//     in_ready           sequencer accepts this cycle
//     in_we1/2           write 1 / write 2 requested
//     in_addr1/2         write 1 / write 2 register address
//     in_data1/2         write 1 / write 2 data
// ---------------------------------------------------------------------------
interface wb_write_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic              in_we1;
    logic [ADDR_W-1:0] in_addr1;
    logic [DATA_W-1:0] in_data1;
    logic              in_we2;
    logic [ADDR_W-1:0] in_addr2;
    logic [DATA_W-1:0] in_data2;

    modport master (
        output in_valid, in_we1, in_addr1, in_data1, in_we2, in_addr2, in_data2,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_we1, in_addr1, in_data1, in_we2, in_addr2, in_data2,
        output in_ready
    );
endinterface

// File: rtl/wb_write_sequencer.sv
// ---------------------------------------------------------------------------
// wb_write_sequencer
//   Writeback stage in front of the single register-file write port.
//   Accepts one retired instruction per handshake (up to two writes),
//   drops writes aimed at the reserved window [RSV_LO, RSV_HI], collapses two
//   writes to the same register into the second one, and serialises the rest
//   onto wr_en/wr_addr/wr_data, stalling MEM/WB for one cycle when a second
//   write is pending.
//
//   Ports
//     clk, rst         clock (rising edge), synchronous active-high reset
//     in_bus           slave side of wb_write_sequencer_if (instruction in)
//     wr_en/addr/data  registered regfile write port
//     drop_err         1-cycle pulse after an accept that hit a reserved reg
//     wr_count         number of issued writes, wraps modulo 2^CNT_W
//
//   Optional feature (macro WB_BYPASS_EN):
//     byp_valid/addr/data expose the write on wr_* when wr_en=1, otherwise the
//     pending second write while in SECOND, otherwise byp_valid=0.
// ---------------------------------------------------------------------------
module wb_write_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int RSV_LO = 8,
    parameter int RSV_HI = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    wb_write_sequencer_if.slave in_bus,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              drop_err,
    output logic [CNT_W-1:0]  wr_count
`ifdef WB_BYPASS_EN
    ,
    output logic              byp_valid,
    output logic [ADDR_W-1:0] byp_addr,
    output logic [DATA_W-1:0] byp_data
`endif
);

    localparam logic [ADDR_W-1:0] RSV_LO_A = ADDR_W'(RSV_LO);
    localparam logic [ADDR_W-1:0] RSV_HI_A = ADDR_W'(RSV_HI);

    typedef enum logic {IDLE, SECOND} state_t;

    state_t state_reg, state_next;

    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic              drop_err_reg;
    logic [CNT_W-1:0]  wr_count_reg;
    logic [ADDR_W-1:0] pend_addr_reg;
    logic [DATA_W-1:0] pend_data_reg;

    logic              accept;
    logic              rsv1, rsv2;
    logic              valid1, valid2;
    logic              dual;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_data;
    logic              latch_pend;

    // Request decode: reserved-window filter and same-register collapse.
    assign rsv1   = (in_bus.in_addr1 >= RSV_LO_A) && (in_bus.in_addr1 <= RSV_HI_A);
    assign rsv2   = (in_bus.in_addr2 >= RSV_LO_A) && (in_bus.in_addr2 <= RSV_HI_A);
    assign valid1 = in_bus.in_we1 && !rsv1;
    assign valid2 = in_bus.in_we2 && !rsv2;
    // Two distinct surviving writes need the extra SECOND cycle.
    assign dual   = valid1 && valid2 && (in_bus.in_addr1 != in_bus.in_addr2);
    assign accept = in_bus.in_valid && (state_reg == IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && dual) state_next = SECOND;
            SECOND:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: handshake and selection of the write to issue next edge.
    always_comb begin
        in_bus.in_ready = (state_reg == IDLE);
        issue_en        = 1'b0;
        issue_addr      = wr_addr_reg;
        issue_data      = wr_data_reg;
        latch_pend      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (dual) begin
                        issue_en   = 1'b1;
                        issue_addr = in_bus.in_addr1;
                        issue_data = in_bus.in_data1;
                        latch_pend = 1'b1;
                    end else if (valid2) begin
                        // Covers both the lone write 2 and the collapsed case.
                        issue_en   = 1'b1;
                        issue_addr = in_bus.in_addr2;
                        issue_data = in_bus.in_data2;
                    end else if (valid1) begin
                        issue_en   = 1'b1;
                        issue_addr = in_bus.in_addr1;
                        issue_data = in_bus.in_data1;
                    end
                end
            end
            SECOND: begin
                issue_en   = 1'b1;
                issue_addr = pend_addr_reg;
                issue_data = pend_data_reg;
            end
            default: ;
        endcase
    end

    // Registered write port, error pulse, counter and pending-write latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            drop_err_reg  <= 1'b0;
            wr_count_reg  <= '0;
            pend_addr_reg <= '0;
            pend_data_reg <= '0;
        end else begin
            wr_en_reg    <= issue_en;
            wr_addr_reg  <= issue_addr;
            wr_data_reg  <= issue_data;
            drop_err_reg <= accept && ((in_bus.in_we1 && rsv1) || (in_bus.in_we2 && rsv2));
            if (issue_en) begin
                wr_count_reg <= wr_count_reg + CNT_W'(1);
            end
            if (latch_pend) begin
                pend_addr_reg <= in_bus.in_addr2;
                pend_data_reg <= in_bus.in_data2;
            end
        end
    end

    assign wr_en    = wr_en_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign drop_err = drop_err_reg;
    assign wr_count = wr_count_reg;

`ifdef WB_BYPASS_EN
    always_comb begin
        byp_valid = wr_en_reg || (state_reg == SECOND);
        byp_addr  = wr_en_reg ? wr_addr_reg : pend_addr_reg;
        byp_data  = wr_en_reg ? wr_data_reg : pend_data_reg;
    end
`endif

endmodule

// File: tb/tb_wb_write_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wb_write_sequencer
//   Directed and randomized transactions against wb_write_sequencer built with
//   CNT_W=4 so the write counter wraps during the run. Expected writes are
//   derived per instruction from the filtering/collapse rules as an ordered
//   list; the counter and held write-port values are tracked by the bench.
// ---------------------------------------------------------------------------
module tb_wb_write_sequencer;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          drop_err;
    logic [CW-1:0] wr_count;
`ifdef WB_BYPASS_EN
    logic          byp_valid;
    logic [AW-1:0] byp_addr;
    logic [DW-1:0] byp_data;
`endif

    wb_write_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    wb_write_sequencer #(
        .DATA_W(DW), .ADDR_W(AW), .RSV_LO(8), .RSV_HI(10), .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_bus   (bus),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .drop_err (drop_err),
        .wr_count (wr_count)
`ifdef WB_BYPASS_EN
        ,
        .byp_valid(byp_valid),
        .byp_addr (byp_addr),
        .byp_data (byp_data)
`endif
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            exp_cnt = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_rsv(input logic [AW-1:0] a);
        return (a >= 4'd8) && (a <= 4'd10);
    endfunction

    // Check one cycle of outputs; en=1 means one write is expected this cycle.
    task automatic expect_out(input string tag, input bit en, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input bit drop, input bit rdy);
        if (en) begin
            exp_cnt   = (exp_cnt + 1) % (1 << CW);
            last_addr = a;
            last_data = d;
        end
        check({tag, ".wr_en"},    32'(wr_en),    32'(en));
        check({tag, ".wr_addr"},  32'(wr_addr),  32'(last_addr));
        check({tag, ".wr_data"},  32'(wr_data),  32'(last_data));
        check({tag, ".drop_err"}, 32'(drop_err), 32'(drop));
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
        check({tag, ".wr_count"}, 32'(wr_count), 32'(exp_cnt));
`ifdef WB_BYPASS_EN
        check({tag, ".byp_valid"}, 32'(byp_valid), 32'(en));
        if (en) begin
            check({tag, ".byp_addr"}, 32'(byp_addr), 32'(a));
            check({tag, ".byp_data"}, 32'(byp_data), 32'(d));
        end
`endif
    endtask

    task automatic idle(input string tag);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        expect_out(tag, 1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    // One instruction. Called #1 after a rising edge with the DUT in IDLE.
    // junk=1 keeps in_valid high with random fields while in_ready=0.
    task automatic send(input string tag,
                        input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input bit we2, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                        input bit junk);
        bit            v1, v2, drop;
        int            n;
        logic [AW-1:0] ea [2];
        logic [DW-1:0] ed [2];
        v1   = we1 && !is_rsv(a1);
        v2   = we2 && !is_rsv(a2);
        drop = (we1 && is_rsv(a1)) || (we2 && is_rsv(a2));
        n    = 0;
        if (v1 && !(v2 && a1 == a2)) begin ea[n] = a1; ed[n] = d1; n++; end
        if (v2)                      begin ea[n] = a2; ed[n] = d2; n++; end

        check({tag, ".ready_pre"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_we1 = we1; bus.in_addr1 = a1; bus.in_data1 = d1;
        bus.in_we2 = we2; bus.in_addr2 = a2; bus.in_data2 = d2;
        @(posedge clk); #1;
        if (n == 2 && junk) begin
            bus.in_valid = 1'b1;
            bus.in_we1 = 1'b1; bus.in_addr1 = 4'($urandom); bus.in_data1 = 16'($urandom);
            bus.in_we2 = 1'b1; bus.in_addr2 = 4'($urandom); bus.in_data2 = 16'($urandom);
        end else begin
            bus.in_valid = 1'b0;
        end
        if (n == 0) expect_out({tag, ".c1"}, 1'b0, '0, '0, drop, 1'b1);
        else        expect_out({tag, ".c1"}, 1'b1, ea[0], ed[0], drop, n != 2);
        if (n == 2) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            expect_out({tag, ".c2"}, 1'b1, ea[1], ed[1], 1'b0, 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_we1 = 1'b0; bus.in_addr1 = '0; bus.in_data1 = '0;
        bus.in_we2 = 1'b0; bus.in_addr2 = '0; bus.in_data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_out("reset", 1'b0, '0, '0, 1'b0, 1'b1);
        idle("idle0");

        send("single",    1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 1'b0);
        send("dual",      1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b1);
        idle("idle1");
        send("rsv1",      1'b1, 4'd9, 16'h0005, 1'b1, 4'd4, 16'h0007, 1'b0);
        send("collapse",  1'b1, 4'd6, 16'hAAAA, 1'b1, 4'd6, 16'h5555, 1'b0);
        send("both_rsv",  1'b1, 4'd8, 16'h0001, 1'b1, 4'd10, 16'h0002, 1'b0);
        send("none",      1'b0, 4'd3, 16'h0001, 1'b0, 4'd5, 16'h0002, 1'b0);
        send("rsv2",      1'b1, 4'd7, 16'h0070, 1'b1, 4'd10, 16'h00A0, 1'b0);
        send("only2",     1'b0, 4'd0, 16'h0000, 1'b1, 4'd11, 16'h0B0B, 1'b0);
        send("lo_edge",   1'b1, 4'd7, 16'h7777, 1'b1, 4'd11, 16'hBBBB, 1'b0);
        send("b2b_a",     1'b1, 4'd12, 16'hC0C0, 1'b1, 4'd13, 16'hD0D0, 1'b0);
        send("b2b_b",     1'b1, 4'd14, 16'hE0E0, 1'b1, 4'd15, 16'hF0F0, 1'b0);
        idle("idle2");

        for (int i = 0; i < 80; i++) begin
            logic [AW-1:0] a1, a2;
            a1 = 4'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom);
            send($sformatf("rnd%0d", i),
                 1'($urandom), a1, 16'($urandom),
                 1'($urandom), a2, 16'($urandom),
                 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle($sformatf("rnd%0d.gap", i));
        end

        // Reset while the second write is pending: that write must vanish.
        check("rst2.ready_pre", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_we1 = 1'b1; bus.in_addr1 = 4'd1; bus.in_data1 = 16'h1234;
        bus.in_we2 = 1'b1; bus.in_addr2 = 4'd2; bus.in_data2 = 16'h5678;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        expect_out("rst2.c1", 1'b1, 4'd1, 16'h1234, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0; last_addr = '0; last_data = '0;
        expect_out("rst2.c2", 1'b0, '0, '0, 1'b0, 1'b1);
        idle("rst2.c3");

        // Sixteen writes from zero bring the 4-bit counter back to 0.
        for (int i = 0; i < 16; i++) begin
            send($sformatf("wrap%0d", i), 1'b1, 4'(i % 8), 16'(i * 3 + 1),
                 1'b0, 4'd0, 16'h0000, 1'b0);
        end
        check("wrap.zero", 32'(wr_count), 32'd0);
        idle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
